// File: rtl/arashi_rr_sched.sv
// Credit-based round-robin read scheduler for the shared arashi memory FIFO.
// Issues at most one registered one-hot grant per cycle and supports a flush/drain sequence.
module arashi_rr_sched #(
  parameter int unsigned THREAD_NUM_WIDTH = 2,
  parameter int unsigned CREDIT_WIDTH     = 2,
  parameter int unsigned MAX_CREDIT       = 3,
  localparam int unsigned THREAD_NUM      = 1 << THREAD_NUM_WIDTH
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [THREAD_NUM-1:0]       req,
  input  logic [THREAD_NUM-1:0]       mask,
  input  logic                        grant_en,
  input  logic [THREAD_NUM-1:0]       done,
  input  logic                        flush,
  output logic                        ready,
  output logic [THREAD_NUM_WIDTH-1:0] thread_id,
  output logic [THREAD_NUM-1:0]       grant_onehot,
  output logic                        busy,
  output logic                        flush_done,
  output logic                        err_credit
);

  localparam logic [CREDIT_WIDTH-1:0] MaxCred = CREDIT_WIDTH'(MAX_CREDIT);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e                        state_q, state_d;
  logic [THREAD_NUM_WIDTH-1:0]   last_q, last_d;
  logic [THREAD_NUM_WIDTH-1:0]   thread_id_q, thread_id_d;
  logic                          ready_q, ready_d;
  logic [THREAD_NUM-1:0]         grant_q, grant_d;
  logic                          err_q, err_d;
  logic [CREDIT_WIDTH-1:0]       credit_q [THREAD_NUM];
  logic [CREDIT_WIDTH-1:0]       credit_d [THREAD_NUM];

  logic [THREAD_NUM-1:0]         elig;
  logic [THREAD_NUM-1:0]         full_vec;
  logic                          all_full;
  logic                          grant_ok;
  logic                          grant_vld;
  logic                          found;
  logic [THREAD_NUM_WIDTH-1:0]   winner;
  logic [THREAD_NUM_WIDTH-1:0]   idx;
  logic [THREAD_NUM-1:0]         grant_vec;

  // Per-thread eligibility and credit-full flags
  always_comb begin
    elig     = '0;
    full_vec = '0;
    for (int unsigned i = 0; i < THREAD_NUM; i++) begin
      elig[i]     = req[i] & ~mask[i] & (credit_q[i] != '0);
      full_vec[i] = (credit_q[i] == MaxCred);
    end
    all_full = &full_vec;
  end

  // Round-robin scan starting just after the last winner
  always_comb begin
    found  = 1'b0;
    winner = last_q;
    idx    = '0;
    for (int unsigned k = 1; k <= THREAD_NUM; k++) begin
      idx = last_q + THREAD_NUM_WIDTH'(k);
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign grant_vld = grant_ok & grant_en & found;
  assign grant_vec = grant_vld ? (THREAD_NUM'(1) << winner) : '0;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (flush) state_d = StDrain;
      StDrain: if (all_full) state_d = StDone;
      StDone:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // FSM: outputs
  always_comb begin
    grant_ok   = (state_q == StRun);
    busy       = (state_q != StRun);
    flush_done = (state_q == StDone);
  end

  // Credit bookkeeping; a simultaneous grant and done cancel out
  always_comb begin
    err_d = err_q;
    for (int unsigned i = 0; i < THREAD_NUM; i++) begin
      credit_d[i] = credit_q[i];
      unique case ({grant_vec[i], done[i]})
        2'b10: credit_d[i] = credit_q[i] - 1'b1;
        2'b01: begin
          if (full_vec[i]) begin
            err_d = 1'b1;
          end else begin
            credit_d[i] = credit_q[i] + 1'b1;
          end
        end
        default: credit_d[i] = credit_q[i];
      endcase
    end
  end

  always_comb begin
    ready_d     = grant_vld;
    grant_d     = grant_vec;
    thread_id_d = grant_vld ? winner : thread_id_q;
    last_d      = grant_vld ? winner : last_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ready_q     <= 1'b0;
      grant_q     <= '0;
      thread_id_q <= '0;
      last_q      <= THREAD_NUM_WIDTH'(THREAD_NUM - 1);
      err_q       <= 1'b0;
      for (int unsigned i = 0; i < THREAD_NUM; i++) begin
        credit_q[i] <= MaxCred;
      end
    end else begin
      ready_q     <= ready_d;
      grant_q     <= grant_d;
      thread_id_q <= thread_id_d;
      last_q      <= last_d;
      err_q       <= err_d;
      for (int unsigned i = 0; i < THREAD_NUM; i++) begin
        credit_q[i] <= credit_d[i];
      end
    end
  end

  assign ready        = ready_q;
  assign thread_id    = thread_id_q;
  assign grant_onehot = grant_q;
  assign err_credit   = err_q;

endmodule

// File: tb/tb_arashi_rr_sched.sv
// Directed bench for arashi_rr_sched with 4 threads and MAX_CREDIT=3.
// Expected values are hand-derived from the round-robin and credit rules.
module tb_arashi_rr_sched;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] req;
  logic [3:0] mask;
  logic       grant_en;
  logic [3:0] done;
  logic       flush;
  logic       ready;
  logic [1:0] thread_id;
  logic [3:0] grant_onehot;
  logic       busy;
  logic       flush_done;
  logic       err_credit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arashi_rr_sched #(
    .THREAD_NUM_WIDTH(2),
    .CREDIT_WIDTH    (2),
    .MAX_CREDIT      (3)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req         (req),
    .mask        (mask),
    .grant_en    (grant_en),
    .done        (done),
    .flush       (flush),
    .ready       (ready),
    .thread_id   (thread_id),
    .grant_onehot(grant_onehot),
    .busy        (busy),
    .flush_done  (flush_done),
    .err_credit  (err_credit)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_grant(input string tag, input int id);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_id"}, 32'(thread_id), 32'(id));
    chk({tag, "_onehot"}, 32'(grant_onehot), 32'(oh));
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_onehot"}, 32'(grant_onehot), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; req = '0; mask = '0; grant_en = 1'b0; done = '0; flush = 1'b0;
    tick();
    tick();
    expect_idle("rst");
    chk("rst_id", 32'(thread_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fdone", 32'(flush_done), 32'd0);
    chk("rst_err", 32'(err_credit), 32'd0);

    // 1: all requesting, done returns each grant one cycle later
    rstn = 1'b1; req = 4'hF; grant_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_grant("rr", i % 4);
      done = 4'b0001 << (i % 4);
    end
    req = '0;
    tick();
    done = '0;
    expect_idle("rr_end");
    chk("rr_err", 32'(err_credit), 32'd0);

    // 2: single thread runs out of credits
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_grant("cred", 2);
    end
    tick();
    expect_idle("cred_empty");
    done = 4'b0100;
    tick();
    expect_idle("cred_ret");
    done = '0;
    tick();
    expect_grant("cred_one", 2);
    tick();
    expect_idle("cred_one_end");
    req = '0; done = 4'b0100;
    for (int i = 0; i < 3; i++) tick();
    done = '0;
    chk("cred_err", 32'(err_credit), 32'd0);

    // 3: grant_en toggling, last holds across idle cycles (last=2 here)
    req = 4'b1010;
    grant_en = 1'b1; tick(); expect_grant("ge1", 3);
    grant_en = 1'b0; tick(); expect_idle("ge0");
    chk("ge0_id_hold", 32'(thread_id), 32'd3);
    grant_en = 1'b1; tick(); expect_grant("ge2", 1);
    grant_en = 1'b0; tick(); expect_idle("ge3");
    chk("ge3_id_hold", 32'(thread_id), 32'd1);
    grant_en = 1'b1; tick(); expect_grant("ge4", 3);
    req = '0; done = 4'b1010; tick();
    done = 4'b1000; tick();
    done = '0;

    // 4: flush with grants outstanding; same-cycle grant still issued
    req = 4'b0111;
    tick(); expect_grant("fl_g0", 0);
    tick(); expect_grant("fl_g1", 1);
    flush = 1'b1;
    tick(); expect_grant("fl_g2", 2);
    chk("fl_busy", 32'(busy), 32'd1);
    flush = 1'b0;
    tick(); expect_idle("fl_nogrant");
    chk("fl_busy2", 32'(busy), 32'd1);
    done = 4'b0001; tick();
    done = 4'b0010; tick();
    chk("fl_fd_early", 32'(flush_done), 32'd0);
    done = 4'b0100; tick();
    chk("fl_fd_last", 32'(flush_done), 32'd0);
    expect_idle("fl_drain");
    done = '0; tick();
    chk("fl_fd", 32'(flush_done), 32'd1);
    chk("fl_done_busy", 32'(busy), 32'd1);
    expect_idle("fl_done");
    flush = 1'b1;  // ignored while in DONE
    tick();
    flush = 1'b0;
    chk("fl_run_busy", 32'(busy), 32'd0);
    chk("fl_run_fd", 32'(flush_done), 32'd0);
    expect_idle("fl_run");
    tick(); expect_grant("fl_resume", 0);
    req = '0; done = 4'b0001; tick();
    done = '0;

    // 5: done at MAX sets sticky error; credit stays at MAX
    done = 4'b0001; tick();
    chk("err_set", 32'(err_credit), 32'd1);
    done = '0; tick();
    chk("err_sticky", 32'(err_credit), 32'd1);
    req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_grant("err_cred", 0);
    end
    tick(); expect_idle("err_cred_empty");
    req = '0; done = 4'b0001;
    for (int i = 0; i < 3; i++) tick();
    done = '0;
    req = 4'b0010;
    tick(); expect_grant("gd_a", 1);
    done = 4'b0010;
    tick(); expect_grant("gd_both", 1);
    done = '0;
    tick(); expect_grant("gd_b", 1);
    tick(); expect_grant("gd_c", 1);
    tick(); expect_idle("gd_empty");
    chk("gd_err", 32'(err_credit), 32'd1);

    // 6: reset during DRAIN (thread 1 still has credits outstanding)
    req = '0; flush = 1'b1; tick();
    flush = 1'b0;
    chk("rd_busy", 32'(busy), 32'd1);
    tick();
    chk("rd_stuck", 32'(busy), 32'd1);
    rstn = 1'b0; tick();
    chk("rd_busy0", 32'(busy), 32'd0);
    expect_idle("rd");
    chk("rd_id", 32'(thread_id), 32'd0);
    chk("rd_err", 32'(err_credit), 32'd0);
    rstn = 1'b1;
    flush = 1'b1; tick();
    flush = 1'b0; tick();
    chk("rd_full_fd", 32'(flush_done), 32'd1);
    tick();
    chk("rd_run", 32'(busy), 32'd0);

    // Masking: last resets to 3, so thread 0 wins first, then mask skips 1
    req = 4'hF;
    tick(); expect_grant("mask_a", 0);
    mask = 4'b0010;
    tick(); expect_grant("mask_b", 2);
    mask = 4'b1111;
    tick(); expect_idle("mask_all");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
